// File: rtl/axi4_lite_master.sv
// AXI4-Lite master: converts single CPU read/write requests into AXI4-Lite
// transactions, one outstanding at a time, with a one-cycle completion pulse.
module axi4_lite_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_resp_valid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_resp_err,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [2:0] {
    IDLE, WRITE, WRESP, RADDR, RDATA, RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_arvalid;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_araddr;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        w_aw_ok;
  logic        w_w_ok;

  // A write channel is finished once its valid has dropped or is
  // handshaking right now; AW and W may finish in either order.
  assign w_aw_ok = !r_awvalid || awready;
  assign w_w_ok  = !r_wvalid  || wready;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    bready         = 1'b0;
    rready         = 1'b0;
    unique case (r_state)
      IDLE: begin
        cpu_req_ready = rst;
        if (cpu_req_valid) w_next = cpu_we ? WRITE : RADDR;
      end
      WRITE: if (w_aw_ok && w_w_ok) w_next = WRESP;
      WRESP: begin
        bready = 1'b1;
        if (bvalid) w_next = RESP;
      end
      RADDR: if (arready) w_next = RDATA;
      RDATA: begin
        rready = 1'b1;
        if (rvalid) w_next = RESP;
      end
      RESP: begin
        cpu_resp_valid = 1'b1;
        w_next         = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_araddr  <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (cpu_req_valid && cpu_we) begin
            r_awaddr  <= cpu_addr;
            r_wdata   <= cpu_wdata;
            r_wstrb   <= cpu_wstrb;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
          end else if (cpu_req_valid) begin
            r_araddr  <= cpu_addr;
            r_arvalid <= 1'b1;
          end
        end
        WRITE: begin
          if (awready) r_awvalid <= 1'b0;
          if (wready)  r_wvalid  <= 1'b0;
        end
        WRESP: if (bvalid) r_err <= |bresp;
        RADDR: if (arready) r_arvalid <= 1'b0;
        RDATA: begin
          if (rvalid) begin
            r_rdata <= rdata;
            r_err   <= |rresp;
          end
        end
        default: ;
      endcase
    end
  end

  assign awaddr       = r_awaddr;
  assign awvalid      = r_awvalid;
  assign wdata        = r_wdata;
  assign wstrb        = r_wstrb;
  assign wvalid       = r_wvalid;
  assign araddr       = r_araddr;
  assign arvalid      = r_arvalid;
  assign cpu_rdata    = r_rdata;
  assign cpu_resp_err = r_err;

endmodule

// File: doc/axi4_lite_master.md
AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 No parameters; all address/data paths SHALL be fixed at 32 bits, strobes at 4 bits.
REQ-002 clk  input  1  single clock; all logic SHALL be rising-edge clocked.
REQ-003 rst  input  1  reset; SHALL be synchronous and active-low.
REQ-004 cpu_req_valid  input  1  CPU request present.
REQ-005 cpu_req_ready  output  1  block idle, request accepted this cycle if valid.
REQ-006 cpu_we  input  1  1 = write, 0 = read.
REQ-007 cpu_addr  input  32  byte address.
REQ-008 cpu_wdata  input  32  write data.
REQ-009 cpu_wstrb  input  4  write byte enables.
REQ-010 cpu_resp_valid  output  1  one-cycle completion pulse.
REQ-011 cpu_rdata  output  32  read data of last completed read.
REQ-012 cpu_resp_err  output  1  completion carried non-OKAY response.
REQ-013 awaddr  output  32  write address.
REQ-014 awvalid  output  1  write address valid.
REQ-015 awready  input  1  slave accepts write address.
REQ-016 wdata  output  32  write data.
REQ-017 wstrb  output  4  write byte strobes.
REQ-018 wvalid  output  1  write data valid.
REQ-019 wready  input  1  slave accepts write data.
REQ-020 bresp  input  2  write response, 00 = OKAY.
REQ-021 bvalid  input  1  write response valid.
REQ-022 bready  output  1  master accepts write response.
REQ-023 araddr  output  32  read address.
REQ-024 arvalid  output  1  read address valid.
REQ-025 arready  input  1  slave accepts read address.
REQ-026 rdata  input  32  read data.
REQ-027 rresp  input  2  read response, 00 = OKAY.
REQ-028 rvalid  input  1  read data valid.
REQ-029 rready  output  1  master accepts read data.

Function
REQ-030 FSM states SHALL be IDLE, WRITE, WRESP, RADDR, RDATA, RESP; one outstanding transaction maximum.
REQ-031 IDLE: cpu_req_ready=1; on cpu_req_valid, SHALL latch addr/wdata/wstrb/we; next state WRITE if we=1, else RADDR; cpu_req_ready=0 in all other states, requests ignored there.
REQ-032 WRITE: awvalid and wvalid SHALL both assert on entry; each SHALL drop the cycle after its own ready is sampled high; channels complete independently, in any order or same cycle.
REQ-033 WRITE -> WRESP when both AW and W handshakes have completed; bready=1 only in WRESP.
REQ-034 WRESP: on bvalid, cpu_resp_err <= (bresp != 00); next RESP.
REQ-035 RADDR: arvalid=1 until arready sampled high, then RDATA; rready=1 only in RDATA.
REQ-036 RDATA: on rvalid, cpu_rdata <= rdata, cpu_resp_err <= (rresp != 00); next RESP.
REQ-037 RESP: cpu_resp_valid=1 for exactly one cycle, then IDLE; cpu_rdata unchanged by writes.
REQ-038 Once valid is asserted, valid and its address/data/strobe SHALL hold stable until handshake; never withdrawn early.
REQ-039 bvalid/rvalid/awready/wready/arready outside their consuming state SHALL be ignored.
REQ-040 Latency with zero-wait slave: cpu_resp_valid SHALL assert 3 cycles after the acceptance cycle (read and write).

Reset
REQ-041 rst low at an edge SHALL force IDLE from any state, mid-transaction included; all valid/ready outputs, cpu_resp_valid, cpu_resp_err, cpu_rdata, awaddr, araddr, wdata, wstrb SHALL be 0; cpu_req_ready=0 while rst low, 1 the first cycle after release; the slave shares this reset.

Verification
REQ-042 Write 0x0000_0010/0xDEAD_BEEF/wstrb F, all readies 1, bresp 00 -> awaddr/wdata driven, resp_valid 3 cycles later, err=0.
REQ-043 Read 0x0000_0020, rdata 0x1234_5678, rresp 00, zero wait -> cpu_rdata=0x1234_5678, err=0, 3-cycle latency.
REQ-044 Write with wready 3 cycles after awready -> awvalid drops first, wvalid held with stable wdata, WRESP only after W handshake.
REQ-045 Read with rresp 10, arready delayed 2 cycles -> arvalid/araddr stable during wait, err=1.
REQ-046 rst low during WRESP with bvalid 0 -> all outputs 0 next edge, IDLE; new read afterwards completes normally.
